// File: rtl/sdmod_ctrl_if.sv
// Signal bundle between the SIGNAL-field sequencer and its neighbours:
// upstream sample stream, SDMOD sample/bit links, DATA path and parsed SIGNAL results.
interface sdmod_ctrl_if;
    logic               start;
    logic               abort;
    logic signed [11:0] di_re;
    logic signed [11:0] di_im;
    logic               di_vld;
    logic               di_rdy;
    logic        [11:0] sd_re;
    logic        [11:0] sd_im;
    logic               sd_vld;
    logic               sd_bit;
    logic               sd_bit_vld;
    logic        [11:0] dd_re;
    logic        [11:0] dd_im;
    logic               dd_vld;
    logic        [3:0]  rate;
    logic        [11:0] length;
    logic               sig_vld;
    logic               sig_err;
    logic               busy;

    modport slave (
        input  start, abort, di_re, di_im, di_vld, sd_bit, sd_bit_vld,
        output di_rdy, sd_re, sd_im, sd_vld, dd_re, dd_im, dd_vld,
               rate, length, sig_vld, sig_err, busy
    );

    modport master (
        output start, abort, di_re, di_im, di_vld, sd_bit, sd_bit_vld,
        input  di_rdy, sd_re, sd_im, sd_vld, dd_re, dd_im, dd_vld,
               rate, length, sig_vld, sig_err, busy
    );
endinterface

// File: rtl/sdmod_ctrl.sv
// Packet sequencer around the SIGNAL-field demodulator: feeds the SIGNAL symbol to SDMOD,
// parses the returned bits, then routes DATA samples. Macro SDMOD_CTRL_RATE_CHK_EN adds rate/tail checks.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start, input closed
// SIG_FEED | forwarding NSC SIGNAL samples to SDMOD
// SIG_WAIT | input closed, collecting NBIT decoded bits, timeout running
// SIG_CHK  | single cycle: parity/reserved (and optional) checks
// DATA     | forwarding samples to the DATA path until abort/start
module sdmod_ctrl #(
    parameter int NSC     = 48,
    parameter int NBIT    = 24,
    parameter int TIMEOUT = 1023
) (
    input logic         clk_i,
    input logic         rst_n_i,
    sdmod_ctrl_if.slave bus
);
    localparam int SCW = $clog2(NSC);
    localparam int BCW = $clog2(NBIT + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SIG_FEED = 3'd1,
        SIG_WAIT = 3'd2,
        SIG_CHK  = 3'd3,
        DATA     = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [SCW-1:0]    smp_cnt_q, smp_cnt_d;
    logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic [NBIT-1:0]   sr_q, sr_d;
    logic [11:0]       sd_re_q, sd_re_d, sd_im_q, sd_im_d;
    logic              sd_vld_q, sd_vld_d;
    logic [11:0]       dd_re_q, dd_re_d, dd_im_q, dd_im_d;
    logic              dd_vld_q, dd_vld_d;
    logic [3:0]        rate_q, rate_d;
    logic [11:0]       length_q, length_d;
    logic              sig_vld_q, sig_vld_d;
    logic              sig_err_q, sig_err_d;
    logic              di_rdy;
    logic              xfer;
    logic              pass;

    assign di_rdy = (state_q == SIG_FEED) || (state_q == DATA);
    assign xfer   = bus.di_vld && di_rdy;

`ifdef SDMOD_CTRL_RATE_CHK_EN
    // Legal 802.11a rate codes all have R4 set; tail bits must be zero.
    assign pass = !(^sr_q[17:0]) && !sr_q[4] && sr_q[3] && (sr_q[NBIT-1:18] == '0);
`else
    logic unused_tail;
    assign unused_tail = ^sr_q[NBIT-1:18];
    assign pass = !(^sr_q[17:0]) && !sr_q[4];
`endif

    always_comb begin
        state_d   = state_q;
        smp_cnt_d = smp_cnt_q;
        bit_cnt_d = bit_cnt_q;
        tmr_d     = tmr_q;
        sr_d      = sr_q;
        sd_re_d   = sd_re_q;
        sd_im_d   = sd_im_q;
        sd_vld_d  = 1'b0;
        dd_re_d   = dd_re_q;
        dd_im_d   = dd_im_q;
        dd_vld_d  = 1'b0;
        rate_d    = rate_q;
        length_d  = length_q;
        sig_vld_d = 1'b0;
        sig_err_d = 1'b0;

        case (state_q)
            IDLE: ;
            SIG_FEED: begin
                if (xfer) begin
                    sd_re_d  = bus.di_re;
                    sd_im_d  = bus.di_im;
                    sd_vld_d = 1'b1;
                    if (smp_cnt_q == SCW'(NSC - 1)) begin
                        smp_cnt_d = '0;
                        bit_cnt_d = '0;
                        tmr_d     = TW'(TIMEOUT - 1);
                        state_d   = SIG_WAIT;
                    end else begin
                        smp_cnt_d = smp_cnt_q + 1'b1;
                    end
                end
            end
            SIG_WAIT: begin
                // A completing bit wins over a coincident timeout.
                if (bus.sd_bit_vld) begin
                    sr_d      = {bus.sd_bit, sr_q[NBIT-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
                if (bus.sd_bit_vld && (bit_cnt_q == BCW'(NBIT - 1))) begin
                    state_d = SIG_CHK;
                end else if (tmr_q == '0) begin
                    sig_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            SIG_CHK: begin
                if (pass) begin
                    rate_d    = sr_q[3:0];
                    length_d  = sr_q[16:5];
                    sig_vld_d = 1'b1;
                    state_d   = DATA;
                end else begin
                    sig_err_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            DATA: begin
                if (xfer) begin
                    dd_re_d  = bus.di_re;
                    dd_im_d  = bus.di_im;
                    dd_vld_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.abort && (state_q == SIG_FEED || state_q == SIG_WAIT || state_q == DATA)) begin
            state_d   = IDLE;
            sig_err_d = 1'b0;
        end

        // Restart overrides everything except the sample already accepted this cycle.
        if (bus.start) begin
            state_d   = SIG_FEED;
            smp_cnt_d = '0;
            bit_cnt_d = '0;
            tmr_d     = '0;
            sr_d      = '0;
            rate_d    = rate_q;
            length_d  = length_q;
            sig_vld_d = 1'b0;
            sig_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            smp_cnt_q <= '0;
            bit_cnt_q <= '0;
            tmr_q     <= '0;
            sr_q      <= '0;
            sd_re_q   <= '0;
            sd_im_q   <= '0;
            sd_vld_q  <= 1'b0;
            dd_re_q   <= '0;
            dd_im_q   <= '0;
            dd_vld_q  <= 1'b0;
            rate_q    <= '0;
            length_q  <= '0;
            sig_vld_q <= 1'b0;
            sig_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            smp_cnt_q <= smp_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            tmr_q     <= tmr_d;
            sr_q      <= sr_d;
            sd_re_q   <= sd_re_d;
            sd_im_q   <= sd_im_d;
            sd_vld_q  <= sd_vld_d;
            dd_re_q   <= dd_re_d;
            dd_im_q   <= dd_im_d;
            dd_vld_q  <= dd_vld_d;
            rate_q    <= rate_d;
            length_q  <= length_d;
            sig_vld_q <= sig_vld_d;
            sig_err_q <= sig_err_d;
        end
    end

    assign bus.di_rdy  = di_rdy;
    assign bus.sd_re   = sd_re_q;
    assign bus.sd_im   = sd_im_q;
    assign bus.sd_vld  = sd_vld_q;
    assign bus.dd_re   = dd_re_q;
    assign bus.dd_im   = dd_im_q;
    assign bus.dd_vld  = dd_vld_q;
    assign bus.rate    = rate_q;
    assign bus.length  = length_q;
    assign bus.sig_vld = sig_vld_q;
    assign bus.sig_err = sig_err_q;
    assign bus.busy    = (state_q != IDLE);
endmodule

// File: tb/tb_sdmod_ctrl.sv
// Directed bench for sdmod_ctrl: good/bad SIGNAL fields, timeout, restart, abort and async reset.
// Expectations follow SDMOD_CTRL_RATE_CHK_EN when the bench is built with it.
module tb_sdmod_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sdmod_ctrl_if bus ();

    sdmod_ctrl dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int failures = 0;
    int sd_cnt = 0;
    int vld_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int n;

    always @(negedge clk) begin
        sd_cnt  += int'(bus.sd_vld);
        vld_cnt += int'(bus.sig_vld);
        err_cnt += int'(bus.sig_err);
        if (bus.sig_vld && bus.sig_err) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic feed(input int cnt, input bit gap, input bit check, input int base);
        for (int i = 0; i < cnt; i++) begin
            if (gap) begin
                bus.di_vld = 1'b0;
                tick();
            end
            bus.di_vld = 1'b1;
            bus.di_re  = 12'(base + i);
            bus.di_im  = 12'(base - i);
            tick();
            if (check) begin
                chk("feed_sd_vld", 32'(bus.sd_vld), 32'd1);
                chk("feed_sd_re", 32'(bus.sd_re), 32'(12'(base + i)));
            end
        end
        bus.di_vld = 1'b0;
    endtask

    task automatic send_bits(input logic [23:0] w, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            bus.sd_bit     = w[i];
            bus.sd_bit_vld = 1'b1;
            tick();
        end
        bus.sd_bit_vld = 1'b0;
        bus.sd_bit     = 1'b0;
    endtask

    // bits: [3:0] rate, [4] reserved, [16:5] length, [17] even parity, [23:18] tail
    function automatic logic [23:0] sigword(input logic [3:0] r, input logic [11:0] l, input bit flip);
        logic p;
        p = (^{l, 1'b0, r}) ^ flip;
        return {6'b0, p, l, 1'b0, r};
    endfunction

    initial begin
        bus.start = 0; bus.abort = 0; bus.di_re = 0; bus.di_im = 0; bus.di_vld = 0;
        bus.sd_bit = 0; bus.sd_bit_vld = 0;
        #23 rst_n = 1'b1;
        tick();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_di_rdy", 32'(bus.di_rdy), 32'd0);
        chk("rst_rate", 32'(bus.rate), 32'd0);
        chk("rst_length", 32'(bus.length), 32'd0);

        // Good packet, 6 Mbps, LENGTH=100 (hand word 0x000C8B: parity 0, six ones already)
        chk("word_6m_100", 32'(sigword(4'b1011, 12'h064, 1'b0)), 32'h000C8B);
        pulse_start();
        chk("feed_di_rdy", 32'(bus.di_rdy), 32'd1);
        chk("feed_busy", 32'(bus.busy), 32'd1);
        chk("feed_sd_vld0", 32'(bus.sd_vld), 32'd0);
        feed(48, 1'b0, 1'b1, 'h100);
        chk("wait_di_rdy", 32'(bus.di_rdy), 32'd0);
        send_bits(24'h000C8B, 24);
        tick();
        chk("t2_sig_vld", 32'(bus.sig_vld), 32'd1);
        chk("t2_sig_err", 32'(bus.sig_err), 32'd0);
        chk("t2_rate", 32'(bus.rate), 32'hB);
        chk("t2_length", 32'(bus.length), 32'h064);
        chk("t2_data_rdy", 32'(bus.di_rdy), 32'd1);
        for (int i = 0; i < 10; i++) begin
            bus.di_vld = 1'b1;
            bus.di_re  = 12'(12'h200 + i);
            tick();
            chk("dd_vld", 32'(bus.dd_vld), 32'd1);
            chk("dd_re", 32'(bus.dd_re), 32'(12'h200 + i));
            chk("dd_sd_vld", 32'(bus.sd_vld), 32'd0);
        end
        bus.di_vld = 1'b0;
        tick();
        chk("dd_vld_idle", 32'(bus.dd_vld), 32'd0);
        chk("t2_sig_vld_once", 32'(bus.sig_vld), 32'd0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_di_rdy", 32'(bus.di_rdy), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);

        // Parity error
        pulse_start();
        feed(48, 1'b0, 1'b0, 'h300);
        send_bits(24'h020C8B, 24);
        tick();
        chk("t3_sig_err", 32'(bus.sig_err), 32'd1);
        chk("t3_sig_vld", 32'(bus.sig_vld), 32'd0);
        chk("t3_busy", 32'(bus.busy), 32'd0);
        chk("t3_di_rdy", 32'(bus.di_rdy), 32'd0);
        chk("t3_rate", 32'(bus.rate), 32'hB);
        chk("t3_length", 32'(bus.length), 32'h064);

        // Timeout: only 20 bits returned
        pulse_start();
        feed(48, 1'b0, 1'b0, 'h400);
        n = 0;
        repeat (20) begin
            bus.sd_bit = 1'b1; bus.sd_bit_vld = 1'b1;
            tick(); n++;
        end
        bus.sd_bit_vld = 1'b0;
        while (!bus.sig_err && n < 1100) begin
            tick(); n++;
        end
        chk("t4_timeout_cycles", 32'(n), 32'd1023);
        chk("t4_sig_err", 32'(bus.sig_err), 32'd1);
        chk("t4_busy", 32'(bus.busy), 32'd0);
        tick();
        chk("t4_sig_err_pulse", 32'(bus.sig_err), 32'd0);

        // Restart with gapped input, then a 54 Mbps field
        sd_cnt = 0;
        pulse_start();
        feed(30, 1'b1, 1'b0, 'h500);
        pulse_start();
        chk("t5_restart_rdy", 32'(bus.di_rdy), 32'd1);
        feed(48, 1'b0, 1'b0, 'h600);
        chk("t5_wait_rdy", 32'(bus.di_rdy), 32'd0);
        send_bits(sigword(4'b1100, 12'h2A5, 1'b0), 24);
        chk("t5_sd_total", 32'(sd_cnt), 32'd78);
        tick();
        chk("t5_sig_vld", 32'(bus.sig_vld), 32'd1);
        chk("t5_rate", 32'(bus.rate), 32'hC);
        chk("t5_length", 32'(bus.length), 32'h2A5);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("t5_abort_rdy", 32'(bus.di_rdy), 32'd0);

        // Start coinciding with the final SIGNAL transfer, then rate code 0011
        pulse_start();
        feed(47, 1'b0, 1'b0, 'h700);
        bus.di_vld = 1'b1;
        bus.di_re  = 12'h7AB;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        bus.di_vld = 1'b0;
        chk("t6_restart_rdy", 32'(bus.di_rdy), 32'd1);
        chk("t6_last_fwd_vld", 32'(bus.sd_vld), 32'd1);
        chk("t6_last_fwd_re", 32'(bus.sd_re), 32'h7AB);
        feed(48, 1'b0, 1'b0, 'h800);
        send_bits(sigword(4'b0011, 12'h010, 1'b0), 24);
        tick();
`ifdef SDMOD_CTRL_RATE_CHK_EN
        chk("t6_sig_err", 32'(bus.sig_err), 32'd1);
        chk("t6_rate_kept", 32'(bus.rate), 32'hC);
        chk("t6_length_kept", 32'(bus.length), 32'h2A5);
`else
        chk("t6_sig_vld", 32'(bus.sig_vld), 32'd1);
        chk("t6_rate", 32'(bus.rate), 32'h3);
        chk("t6_length", 32'(bus.length), 32'h010);
`endif

        // Good packet again, then asynchronous reset in the middle of DATA
        pulse_start();
        feed(48, 1'b0, 1'b0, 'h900);
        send_bits(24'h000C8B, 24);
        tick();
        chk("t1_pre_sig_vld", 32'(bus.sig_vld), 32'd1);
        bus.di_vld = 1'b1;
        bus.di_re  = 12'h0F1;
        tick();
        chk("t1_pre_dd_vld", 32'(bus.dd_vld), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t1_di_rdy", 32'(bus.di_rdy), 32'd0);
        chk("t1_sd_vld", 32'(bus.sd_vld), 32'd0);
        chk("t1_sd_re", 32'(bus.sd_re), 32'd0);
        chk("t1_dd_vld", 32'(bus.dd_vld), 32'd0);
        chk("t1_dd_re", 32'(bus.dd_re), 32'd0);
        chk("t1_rate", 32'(bus.rate), 32'd0);
        chk("t1_length", 32'(bus.length), 32'd0);
        chk("t1_sig_vld", 32'(bus.sig_vld), 32'd0);
        chk("t1_sig_err", 32'(bus.sig_err), 32'd0);
        chk("t1_busy", 32'(bus.busy), 32'd0);
        bus.di_vld = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        chk("never_both", 32'(both_cnt), 32'd0);
`ifdef SDMOD_CTRL_RATE_CHK_EN
        chk("sig_vld_total", 32'(vld_cnt), 32'd3);
        chk("sig_err_total", 32'(err_cnt), 32'd3);
`else
        chk("sig_vld_total", 32'(vld_cnt), 32'd4);
        chk("sig_err_total", 32'(err_cnt), 32'd2);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
